// File: rtl/seq_divider.sv
// seq_divider: restoring divider, 2*WIDTH / WIDTH, one quotient bit per cycle MSB first.
// Define SEQ_DIVIDER_EARLY_EXIT_EN to skip the dividend's leading zeros (data-dependent latency).
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               busy,
  output logic               finish
);
  localparam int DW = 2*WIDTH;
  localparam int CW = $clog2(DW);
  typedef enum logic {IDLE, CALC} state_t;
  state_t            state;
  logic [DW-1:0]     d, q, q_nxt;
  logic [WIDTH-1:0]  v, r, r_nxt;
  logic [WIDTH:0]    t;
  logic [CW-1:0]     cnt;
  logic              ge;
  always_comb begin
    t     = {r, d[DW-1]};
    ge    = t >= {1'b0, v};
    r_nxt = ge ? WIDTH'(t - {1'b0, v}) : t[WIDTH-1:0];
    q_nxt = {q[DW-2:0], ge};
  end
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
  // Clamped to DW-1 so a zero dividend still runs one CALC cycle.
  function automatic logic [CW-1:0] lead_zeros(input logic [DW-1:0] x);
    lead_zeros = CW'(DW-1);
    for (int i = 0; i < DW; i++)
      if (x[i]) lead_zeros = CW'(DW-1-i);
  endfunction
  logic [CW-1:0] lz;
  always_comb lz = lead_zeros(dividend);
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      d           <= '0;
      v           <= '0;
      r           <= '0;
      q           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      finish      <= 1'b0;
    end else begin
      finish <= 1'b0;
      if (finish) div_by_zero <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
          // Skipped leading bits would have produced all-ones quotient bits for a zero divisor.
          d   <= dividend << lz;
          cnt <= lz;
          q   <= {DW{divisor == '0}};
`else
          d   <= dividend;
          cnt <= '0;
          q   <= '0;
`endif
          v     <= divisor;
          r     <= '0;
          busy  <= 1'b1;
          state <= CALC;
        end
      end else begin
        d   <= d << 1;
        r   <= r_nxt;
        q   <= q_nxt;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(DW-1)) begin
          quotient    <= q_nxt;
          remainder   <= r_nxt;
          div_by_zero <= v == '0;
          finish      <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vector table plus handshake corner sequences for seq_divider (WIDTH=8).
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero, busy, finish;
  int checks = 0;
  int failures = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .busy(busy), .finish(finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          lat_ct;
    int          lat_ee;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] dd, input logic [7:0] dv);
    start = 1'b1;
    dividend = dd;
    divisor = dv;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int b);
    n = 0;
    b = 0;
    while (!finish && n < 40) begin
      if (busy) b++;
      tick();
      n++;
    end
  endtask

  function automatic int lat_of(input vec_t x);
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    return x.lat_ee;
`else
    return x.lat_ct;
`endif
  endfunction

  task automatic run_vec(input string name, input vec_t x);
    int n, b;
    launch(x.dd, x.dv);
    chk({name, " busy_after_start"}, busy, 1);
    wait_done(n, b);
    chk({name, " latency"}, n, lat_of(x));
    chk({name, " busy_cycles"}, b, lat_of(x));
    chk({name, " quotient"}, quotient, x.q);
    chk({name, " remainder"}, remainder, x.r);
    chk({name, " div_by_zero"}, div_by_zero, x.dbz);
    chk({name, " busy_at_finish"}, busy, 0);
  endtask

  initial begin
    int n, b, fin_seen;
    vecs[0] = '{16'd1000,   8'd7,   16'd142,  8'd6,   1'b0, 16, 10};
    vecs[1] = '{16'hFFFF,   8'hFF,  16'd257,  8'd0,   1'b0, 16, 16};
    vecs[2] = '{16'hFFFF,   8'd1,   16'hFFFF, 8'd0,   1'b0, 16, 16};
    vecs[3] = '{16'd100,    8'd0,   16'hFFFF, 8'd100, 1'b1, 16, 7};
    vecs[4] = '{16'd9,      8'd2,   16'd4,    8'd1,   1'b0, 16, 4};
    vecs[5] = '{16'd50,     8'd5,   16'd10,   8'd0,   1'b0, 16, 6};
    vecs[6] = '{16'd200,    8'd9,   16'd22,   8'd2,   1'b0, 16, 8};
    vecs[7] = '{16'd5,      8'd3,   16'd1,    8'd2,   1'b0, 16, 3};
    vecs[8] = '{16'd0,      8'd3,   16'd0,    8'd0,   1'b0, 16, 1};
    vecs[9] = '{16'd12345,  8'd100, 16'd123,  8'd45,  1'b0, 16, 14};

    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    tick();
    tick();
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset div_by_zero", div_by_zero, 0);
    chk("reset busy", busy, 0);
    chk("reset finish", finish, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
      tick();
      chk($sformatf("vec%0d finish_one_cycle", i), finish, 0);
      chk($sformatf("vec%0d dbz_cleared", i), div_by_zero, 0);
    end

    // Back-to-back: second start asserted in the finish cycle.
    launch(16'hFFFF, 8'hFF);
    wait_done(n, b);
    chk("b2b first quotient", quotient, 257);
    chk("b2b first finish", finish, 1);
    launch(16'hFFFF, 8'd1);
    chk("b2b accepted busy", busy, 1);
    chk("b2b result held", quotient, 257);
    wait_done(n, b);
    chk("b2b second latency", n, lat_of(vecs[2]));
    chk("b2b second quotient", quotient, 16'hFFFF);
    chk("b2b second remainder", remainder, 0);

    // Divide by zero then a normal division: flag clears, quotient holds until next result.
    tick();
    launch(16'd100, 8'd0);
    wait_done(n, b);
    chk("dbz latency", n, lat_of(vecs[3]));
    chk("dbz flag", div_by_zero, 1);
    chk("dbz quotient", quotient, 16'hFFFF);
    chk("dbz remainder", remainder, 100);
    launch(16'd9, 8'd2);
    chk("after dbz flag cleared", div_by_zero, 0);
    chk("after dbz finish cleared", finish, 0);
    chk("after dbz quotient held", quotient, 16'hFFFF);
    wait_done(n, b);
    chk("after dbz quotient", quotient, 4);
    chk("after dbz remainder", remainder, 1);
    chk("after dbz flag", div_by_zero, 0);

    // Start during CALC is ignored.
    tick();
    launch(16'd50, 8'd5);
    repeat (5) tick();
    start = 1'b1;
    dividend = 16'd77;
    divisor = 8'd3;
    tick();
    start = 1'b0;
    wait_done(n, b);
    chk("ignored start latency", n + 6, lat_of(vecs[5]));
    chk("ignored start quotient", quotient, 10);
    chk("ignored start remainder", remainder, 0);
    tick();
    chk("ignored start no relaunch", busy, 0);

    // Reset mid-CALC aborts without a finish pulse.
    launch(16'd200, 8'd9);
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort div_by_zero", div_by_zero, 0);
    chk("abort busy", busy, 0);
    chk("abort finish", finish, 0);
    rst_n = 1'b1;
    fin_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (finish || busy) fin_seen++;
    end
    chk("abort no finish or busy", fin_seen, 0);
    run_vec("after abort", vecs[6]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
